// File: rtl/bfm_ahbapb_pkg.sv
// Shared definitions for the AHB-Lite to APB bridge: FSM states, HTRANS codes
// and the access timeout counter width.
package bfm_ahbapb_pkg;

  localparam int CNT_W = 16;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } state_t;

  // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY get a zero-wait OKAY.
  function automatic logic trans_active(input logic [1:0] htrans);
    logic act;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
      default:                   act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/bfm_apb_timeout.sv
// Loadable up-counter with clear, enable and terminal-count compare, used to
// bound the number of APB ACCESS cycles.
module bfm_apb_timeout
  import bfm_ahbapb_pkg::*;
#(
  parameter logic [CNT_W-1:0] TC_VAL = CNT_W'(255)
) (
  input  logic             HCLK,
  input  logic             HRESETN,
  input  logic             clr,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  input  logic             en,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/bfm_ahbl2apb.sv
// AHB-Lite slave to APB master bridge on a single clock. TPD is kept for
// interface compatibility; this synthesizable view models zero output delay.
//
// state     | meaning
// ST_IDLE   | no APB transfer, HREADYOUT=1, accepts new address phase
// ST_SETUP  | APB setup phase (PSEL=1, PENABLE=0)
// ST_ACCESS | APB access phase, waits for PREADY or timeout
// ST_ERR1   | first error cycle (HRESP=1, HREADYOUT=0)
// ST_ERR2   | second error cycle (HRESP=1, HREADYOUT=1), accepts new transfer
module bfm_ahbl2apb
  import bfm_ahbapb_pkg::*;
#(
  parameter int TPD     = 1,
  parameter int TIMEOUT = 256
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        PSEL,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic        PENABLE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("bfm_ahbl2apb: TIMEOUT out of range 2..65535");
  end
  if (TPD < 0) begin : g_bad_tpd
    $error("bfm_ahbl2apb: TPD must be non-negative");
  end

  localparam logic [CNT_W-1:0] TO_TC = CNT_W'(TIMEOUT - 1);

  state_t state, state_nxt;
  logic   accept;
  logic   cnt_en;
  logic   to_tc;

  assign accept = ((state == ST_IDLE) || (state == ST_ERR2)) &&
                  HSEL && HREADY && trans_active(HTRANS);

  bfm_apb_timeout #(
    .TC_VAL (TO_TC)
  ) u_timeout (
    .HCLK    (HCLK),
    .HRESETN (HRESETN),
    .clr     (accept),
    .ld      (1'b0),
    .ld_val  ('0),
    .en      (cnt_en),
    .tc      (to_tc)
  );

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      state  <= ST_IDLE;
      PADDR  <= '0;
      PWRITE <= 1'b0;
      HRDATA <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        PADDR  <= HADDR;
        PWRITE <= HWRITE;
      end
      if ((state == ST_ACCESS) && PREADY && !PSLVERR && !PWRITE) begin
        HRDATA <= PRDATA;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    PWDATA    = '0;
    cnt_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        PSEL      = 1'b1;
        HREADYOUT = 1'b0;
        PWDATA    = HWDATA;
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        PSEL      = 1'b1;
        PENABLE   = 1'b1;
        HREADYOUT = 1'b0;
        PWDATA    = HWDATA;
        cnt_en    = 1'b1;
        // A completing PREADY wins over a coincident timeout.
        if (PREADY) begin
          state_nxt = PSLVERR ? ST_ERR1 : ST_IDLE;
        end else if (to_tc) begin
          state_nxt = ST_ERR1;
        end
      end
      ST_ERR1: begin
        HRESP     = 1'b1;
        HREADYOUT = 1'b0;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP     = 1'b1;
        state_nxt = accept ? ST_SETUP : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bfm_ahbl2apb.sv
// Directed bench for bfm_ahbl2apb with TIMEOUT=4 and HREADY looped back from
// HREADYOUT as in a single-slave AHB-Lite system.
module tb_bfm_ahbl2apb;

  logic        clk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  wire         hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        psel;
  logic [31:0] paddr;
  logic        pwrite;
  logic        penable;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int n_vec = 0;
  int n_err = 0;
  int waits;
  int acc;

  assign hready = hreadyout;

  always #5 clk = ~clk;

  bfm_ahbl2apb #(
    .TPD     (1),
    .TIMEOUT (4)
  ) dut (
    .HCLK      (clk),
    .HRESETN   (hresetn),
    .HSEL      (hsel),
    .HADDR     (haddr),
    .HWRITE    (hwrite),
    .HTRANS    (htrans),
    .HWDATA    (hwdata),
    .HREADY    (hready),
    .HREADYOUT (hreadyout),
    .HRESP     (hresp),
    .HRDATA    (hrdata),
    .PSEL      (psel),
    .PADDR     (paddr),
    .PWRITE    (pwrite),
    .PENABLE   (penable),
    .PWDATA    (pwdata),
    .PRDATA    (prdata),
    .PREADY    (pready),
    .PSLVERR   (pslverr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [1:0] t);
    hsel   = 1'b1;
    haddr  = a;
    hwrite = w;
    htrans = t;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask

  initial begin
    #20000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    hresetn = 1'b0;
    hsel    = 1'b0;
    haddr   = '0;
    hwrite  = 1'b0;
    htrans  = 2'b00;
    hwdata  = '0;
    prdata  = '0;
    pready  = 1'b1;
    pslverr = 1'b0;
    tick();
    tick();

    chk("rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst_hresp",     32'(hresp),     32'd0);
    chk("rst_hrdata",    hrdata,         32'h0);
    chk("rst_psel",      32'(psel),      32'd0);
    chk("rst_penable",   32'(penable),   32'd0);
    chk("rst_paddr",     paddr,          32'h0);
    chk("rst_pwrite",    32'(pwrite),    32'd0);
    hresetn = 1'b1;

    // BUSY with HSEL=1, then NONSEQ with HSEL=0: neither starts APB
    addr_phase(32'h0000_0010, 1'b1, 2'b01);
    tick();
    chk("busy_psel",      32'(psel),      32'd0);
    chk("busy_hreadyout", 32'(hreadyout), 32'd1);
    addr_phase(32'h0000_0020, 1'b1, 2'b10);
    hsel = 1'b0;
    tick();
    chk("nosel_psel",     32'(psel),      32'd0);
    chk("nosel_paddr",    paddr,          32'h0);

    // write, zero-wait slave
    addr_phase(32'h0100_0004, 1'b1, 2'b10);
    tick();
    bus_idle();
    hwdata = 32'hDEAD_BEEF;
    #1;
    chk("wr_setup_psel_pen", {30'd0, psel, penable}, 32'b10);
    chk("wr_setup_hready",   32'(hreadyout), 32'd0);
    chk("wr_setup_pwdata",   pwdata,         32'hDEAD_BEEF);
    chk("wr_setup_paddr",    paddr,          32'h0100_0004);
    chk("wr_setup_pwrite",   32'(pwrite),    32'd1);
    tick();
    chk("wr_acc_psel_pen",   {30'd0, psel, penable}, 32'b11);
    chk("wr_acc_hready",     32'(hreadyout), 32'd0);
    chk("wr_acc_pwdata",     pwdata,         32'hDEAD_BEEF);
    tick();
    chk("wr_done_hready",    32'(hreadyout), 32'd1);
    chk("wr_done_hresp",     32'(hresp),     32'd0);
    chk("wr_done_psel",      32'(psel),      32'd0);
    chk("wr_done_pwdata",    pwdata,         32'h0);
    chk("wr_done_paddr",     paddr,          32'h0100_0004);
    chk("wr_done_hrdata",    hrdata,         32'h0);

    // read, PREADY low for 3 ACCESS cycles; 4th ACCESS hits terminal count with PREADY=1
    pready = 1'b0;
    prdata = 32'h1234_5678;
    addr_phase(32'h0200_0000, 1'b0, 2'b10);
    tick();
    bus_idle();
    waits = 0;
    acc   = 0;
    while (hreadyout === 1'b0 && waits < 20) begin
      if (penable) acc++;
      pready = (acc >= 4);
      waits++;
      tick();
    end
    chk("rd_waits",  32'(waits),     32'd5);
    chk("rd_hrdata", hrdata,         32'h1234_5678);
    chk("rd_hresp",  32'(hresp),     32'd0);
    chk("rd_psel",   32'(psel),      32'd0);
    chk("rd_pwrite", 32'(pwrite),    32'd0);

    // slave error on a write
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = 32'hBAD0_0001;
    addr_phase(32'h0000_0300, 1'b1, 2'b10);
    tick();
    bus_idle();
    tick();
    chk("se_acc_penable", 32'(penable),   32'd1);
    tick();
    pslverr = 1'b0;
    chk("se_err1_hresp",  32'(hresp),     32'd1);
    chk("se_err1_hready", 32'(hreadyout), 32'd0);
    chk("se_err1_psel",   32'(psel),      32'd0);
    tick();
    chk("se_err2_hresp",  32'(hresp),     32'd1);
    chk("se_err2_hready", 32'(hreadyout), 32'd1);
    tick();
    chk("se_idle_hresp",  32'(hresp),     32'd0);
    chk("se_idle_hready", 32'(hreadyout), 32'd1);
    chk("se_hrdata_kept", hrdata,         32'h1234_5678);

    // timeout: PREADY never rises
    pready = 1'b0;
    addr_phase(32'h0000_0400, 1'b0, 2'b10);
    tick();
    bus_idle();
    tick();
    acc = 0;
    while (penable === 1'b1 && acc < 20) begin
      acc++;
      tick();
    end
    chk("to_access_cycles", 32'(acc),       32'd4);
    chk("to_err1_psel",     32'(psel),      32'd0);
    chk("to_err1_hresp",    32'(hresp),     32'd1);
    chk("to_err1_hready",   32'(hreadyout), 32'd0);
    tick();
    chk("to_err2_hresp",    32'(hresp),     32'd1);
    chk("to_err2_hready",   32'(hreadyout), 32'd1);
    tick();
    chk("to_idle_hresp",    32'(hresp),     32'd0);
    chk("to_hrdata_kept",   hrdata,         32'h1234_5678);

    // back-to-back: NONSEQ, SEQ in the final ready cycle, error, then read in ERR2
    pready = 1'b1;
    addr_phase(32'h0000_0500, 1'b1, 2'b10);
    tick();
    bus_idle();
    hwdata = 32'h1111_1111;
    tick();
    chk("b2b1_acc_penable", 32'(penable), 32'd1);
    tick();
    chk("b2b1_final_ready", 32'(hreadyout), 32'd1);
    addr_phase(32'h0000_0504, 1'b1, 2'b11);
    tick();
    bus_idle();
    hwdata = 32'h2222_2222;
    #1;
    chk("b2b2_setup_psel_pen", {30'd0, psel, penable}, 32'b10);
    chk("b2b2_setup_paddr",    paddr,  32'h0000_0504);
    chk("b2b2_setup_pwdata",   pwdata, 32'h2222_2222);
    tick();
    pslverr = 1'b1;
    tick();
    pslverr = 1'b0;
    chk("b2b2_err1_hresp",  32'(hresp),     32'd1);
    chk("b2b2_err1_hready", 32'(hreadyout), 32'd0);
    tick();
    chk("b2b2_err2_hready", 32'(hreadyout), 32'd1);
    prdata = 32'hCAFE_F00D;
    addr_phase(32'h0000_0600, 1'b0, 2'b10);
    tick();
    bus_idle();
    chk("b2b3_setup_psel_pen", {30'd0, psel, penable}, 32'b10);
    chk("b2b3_setup_paddr",    paddr,          32'h0000_0600);
    chk("b2b3_setup_hresp",    32'(hresp),     32'd0);
    chk("b2b3_setup_hready",   32'(hreadyout), 32'd0);
    tick();
    tick();
    chk("b2b3_done_hrdata",    hrdata,         32'hCAFE_F00D);
    chk("b2b3_done_hresp",     32'(hresp),     32'd0);
    chk("b2b3_done_hready",    32'(hreadyout), 32'd1);

    // reset asserted for one cycle mid-ACCESS
    pready = 1'b0;
    addr_phase(32'h0000_0700, 1'b1, 2'b10);
    tick();
    bus_idle();
    tick();
    chk("rstmid_acc_penable", 32'(penable), 32'd1);
    hresetn = 1'b0;
    tick();
    hresetn = 1'b1;
    chk("rstmid_psel",    32'(psel),      32'd0);
    chk("rstmid_penable", 32'(penable),   32'd0);
    chk("rstmid_hready",  32'(hreadyout), 32'd1);
    chk("rstmid_paddr",   paddr,          32'h0);
    chk("rstmid_hrdata",  hrdata,         32'h0);
    pready = 1'b1;
    addr_phase(32'h0000_0704, 1'b1, 2'b10);
    tick();
    bus_idle();
    hwdata = 32'h5A5A_5A5A;
    #1;
    chk("post_setup_paddr",  paddr,  32'h0000_0704);
    chk("post_setup_pwdata", pwdata, 32'h5A5A_5A5A);
    tick();
    chk("post_acc_psel_pen", {30'd0, psel, penable}, 32'b11);
    tick();
    chk("post_done_hready",  32'(hreadyout), 32'd1);
    chk("post_done_hresp",   32'(hresp),     32'd0);
    chk("post_done_psel",    32'(psel),      32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bfm_ahbl2apb.md
BFM_AHBL2APB -- requirements
Module: bfm_ahbl2apb

Interface
REQ-001 Parameter TPD, default 1: propagation delay in ns applied to every APB output.
REQ-002 Parameter TIMEOUT, default 256: maximum ACCESS cycles before abort; legal range 2..65535.
REQ-003 Port HCLK, input, 1: single clock for both the AHB-Lite and APB sides.
REQ-004 Port HRESETN, input, 1: reset, synchronous and active-low.
REQ-005 Port HSEL, input, 1: AHB slave select.
REQ-006 Port HADDR, input, 32: AHB address.
REQ-007 Port HWRITE, input, 1: AHB write, 1 = write.
REQ-008 Port HTRANS, input, 2: AHB transfer type.
REQ-009 Port HWDATA, input, 32: AHB write data.
REQ-010 Port HREADY, input, 1: bus-wide AHB ready.
REQ-011 Port HREADYOUT, output, 1: slave ready.
REQ-012 Port HRESP, output, 1: 1 = ERROR.
REQ-013 Port HRDATA, output, 32: AHB read data.
REQ-014 Port PSEL, output, 1: APB select.
REQ-015 Port PADDR, output, 32: APB address.
REQ-016 Port PWRITE, output, 1: APB write.
REQ-017 Port PENABLE, output, 1: APB enable.
REQ-018 Port PWDATA, output, 32: APB write data.
REQ-019 Port PRDATA, input, 32: APB read data.
REQ-020 Port PREADY, input, 1: APB ready.
REQ-021 Port PSLVERR, input, 1: APB slave error.

Function
REQ-022 States: IDLE, SETUP, ACCESS, ERR1, ERR2.
REQ-023 Transfer accept: HSEL=1, HREADY=1 and HTRANS[1]=1 while in IDLE or ERR2.
  - On accept: register HADDR into PADDR and HWRITE into PWRITE.
  - Next state: SETUP.
REQ-024 IDLE/BUSY transfers, or HSEL=0: no APB activity; response is OKAY with zero wait states.
REQ-025 SETUP:
  - PSEL=1, PENABLE=0, HREADYOUT=0.
  - Always advances to ACCESS after one cycle.
REQ-026 ACCESS:
  - PSEL=1, PENABLE=1, HREADYOUT=0.
  - Holds until PREADY=1.
REQ-027 PWDATA is driven directly from HWDATA during SETUP and ACCESS, and is 0 otherwise. The AHB master holds HWDATA stable across wait states.
REQ-028 ACCESS with PREADY=1 and PSLVERR=0:
  - Next state: IDLE.
  - Next cycle: HREADYOUT=1, HRESP=0.
  - HRDATA = PRDATA captured on a read; HRDATA unchanged on a write.
REQ-029 ACCESS with PREADY=1 and PSLVERR=1:
  - Next state: ERR1, with HRESP=1, HREADYOUT=0.
  - Then ERR2, with HRESP=1, HREADYOUT=1.
  - Then IDLE.
REQ-030 Timeout:
  - A 16-bit counter clears on SETUP entry and increments every ACCESS cycle.
  - If it reaches TIMEOUT-1 with PREADY=0, the APB transfer is abandoned: PSEL=0 and PENABLE=0 next cycle, and the state goes to ERR1.
  - PREADY=1 in that same cycle takes priority over the timeout.
REQ-031 Outside SETUP and ACCESS: PSEL=0, PENABLE=0. PADDR and PWRITE retain their last values.
REQ-032 Throughput: a zero-wait APB slave completes a transfer in 3 HCLK cycles (address phase, SETUP, ACCESS), plus a final HREADYOUT=1 cycle that may overlap the next address phase.
REQ-033 A transfer accepted in ERR2 proceeds normally; the error response is not repeated.

Reset
REQ-034 With HRESETN=0 at a rising HCLK edge, the block enters IDLE from any state, including mid-ACCESS.
REQ-035 Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, timeout counter=0.
REQ-036 Reset has no asynchronous path; outputs change only on HCLK edges, plus TPD.

Structure
REQ-037 The state encoding, the HTRANS encodings (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11) and the counter width of 16 reside in a shared package, bfm_ahbapb_pkg.
REQ-038 One sub-module: bfm_apb_timeout, the loadable 16-bit counter with clear, enable and terminal-count output.
REQ-039 All remaining logic is one clocked process plus a combinational output decode.

Verification
REQ-040 Write test:
  - Stimulus: HADDR=0x0100_0004, HWDATA=0xDEADBEEF, PREADY tied high.
  - Response: PSEL/PENABLE sequence 10, 11; PWDATA=0xDEADBEEF throughout; HREADYOUT low for 2 cycles; HRESP=0.
REQ-041 Read test:
  - Stimulus: read of 0x0200_0000, PREADY low for 3 ACCESS cycles, PRDATA=0x12345678.
  - Response: HRDATA=0x12345678 in the cycle after PREADY; total of 5 wait cycles.
REQ-042 Slave-error test:
  - Stimulus: PSLVERR=1 with PREADY=1.
  - Response: HRESP=1 for 2 cycles; HREADYOUT 0 then 1; state returns to IDLE.
REQ-043 Timeout test:
  - Stimulus: TIMEOUT=4, PREADY held 0.
  - Response: PSEL drops after 4 ACCESS cycles; ERR1/ERR2 error response follows.
REQ-044 Back-to-back test:
  - Stimulus: NONSEQ then SEQ write, with the second address phase during the final HREADYOUT=1 cycle; then a third transfer presented in ERR2 after an injected error.
  - Response: all transfers are accepted, no cycle gap.
REQ-045 Reset test:
  - Stimulus: HRESETN=0 asserted for 1 cycle mid-ACCESS.
  - Response: next edge PSEL=0, PENABLE=0, HREADYOUT=1; a subsequent write completes normally.
